// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Define UART_ARB_TAG_EN to precede each byte with a TAG_PREFIX|grant_id frame.
module uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int D_BITS = 8,
   parameter logic [D_BITS-1:0] TAG_PREFIX = D_BITS'(8'hA0)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*D_BITS-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic [D_BITS-1:0]         tx_din,
   output logic                      tx_start,
   input  logic                      tx_done_tick,
   output logic                      busy,
   output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [GW:0] NR = (GW+1)'(N_REQ);
   localparam logic [GW-1:0] LAST = GW'(N_REQ - 1);

`ifdef UART_ARB_TAG_EN
   typedef enum logic [1:0] {IDLE, WAIT_TAG, WAIT_DATA} state_t;
`else
   typedef enum logic [1:0] {IDLE, WAIT_DATA} state_t;
`endif

   state_t            state;
   logic [GW-1:0]     rr_ptr;
   logic [GW-1:0]     g;
   logic [GW:0]       sum;
   logic              found;
   logic [D_BITS-1:0] bytes [N_REQ];

`ifdef UART_ARB_TAG_EN
   logic [D_BITS-1:0] data;
`else
   logic unused_tag;
   assign unused_tag = ^TAG_PREFIX;
`endif

   for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
      assign bytes[i] = req_data[i*D_BITS +: D_BITS];
   end

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      g = '0;
      found = 1'b0;
      sum = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (GW+1)'(k);
         if (sum >= NR) sum = sum - NR;
         if (req_valid[sum[GW-1:0]]) begin
            g = sum[GW-1:0];
            found = 1'b1;
         end
      end
   end

   assign req_ready = (reset_n && state == IDLE && found)
                    ? (N_REQ'(1) << g) : '0;
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         tx_start <= 1'b0;
         tx_din   <= '0;
         grant_id <= '0;
`ifdef UART_ARB_TAG_EN
         data     <= '0;
`endif
      end else begin
         tx_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant_id <= g;
                  tx_start <= 1'b1;
`ifdef UART_ARB_TAG_EN
                  data   <= bytes[g];
                  tx_din <= TAG_PREFIX | D_BITS'(g);
                  state  <= WAIT_TAG;
`else
                  tx_din <= bytes[g];
                  state  <= WAIT_DATA;
`endif
               end
            end
`ifdef UART_ARB_TAG_EN
            WAIT_TAG: begin
               if (tx_done_tick && !tx_start) begin
                  tx_din   <= data;
                  tx_start <= 1'b1;
                  state    <= WAIT_DATA;
               end
            end
`endif
            WAIT_DATA: begin
               // a done tick coinciding with our own start pulse is stale
               if (tx_done_tick && !tx_start) begin
                  rr_ptr <= (grant_id == LAST) ? '0 : grant_id + GW'(1);
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a cycle-count transmitter model.
// Honours UART_ARB_TAG_EN when the design is built with it.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int F = 6;
`ifdef UART_ARB_TAG_EN
   localparam int FPG = 2;
`else
   localparam int FPG = 1;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic [7:0]  tx_din;
   logic        tx_start;
   logic        tx_done_tick = 1'b0;
   logic        busy;
   logic [1:0]  grant_id;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit auto_tx = 0;
   int tx_cnt = 0;
   logic [7:0] sent [$];
   int start_cyc [$];
   logic [7:0] exp_q [$];

   typedef struct {
      logic [3:0] valid;
      logic [7:0] base;
      logic [3:0] ready;
      logic [1:0] grant;
      logic [7:0] din;
   } vec_t;
   vec_t vt [8];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(4), .D_BITS(8), .TAG_PREFIX(8'hA0)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .tx_din(tx_din),
      .tx_start(tx_start),
      .tx_done_tick(tx_done_tick),
      .busy(busy),
      .grant_id(grant_id)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [7:0] b);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   // One clock; when enabled, the transmitter model answers each start
   // with a done tick F samples later.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (auto_tx) begin
         tx_done_tick = 1'b0;
         if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done_tick = 1'b1;
         end
         if (tx_start) begin
            tx_cnt = F;
            sent.push_back(tx_din);
            start_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic done_pulse();
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
   endtask

   // Called at the sample right after an acceptance edge.
   task automatic serve(input string nm, input logic [1:0] eg,
                        input logic [7:0] ed);
      check({nm, " start"}, tx_start, 1);
      check({nm, " grant"}, grant_id, eg);
      check({nm, " busy"}, busy, 1);
      check({nm, " ready_busy"}, req_ready, 0);
`ifdef UART_ARB_TAG_EN
      check({nm, " tag"}, tx_din, 8'hA0 | 8'(eg));
      step();
      done_pulse();
      check({nm, " data_start"}, tx_start, 1);
      check({nm, " busy_tag"}, busy, 1);
`endif
      check({nm, " din"}, tx_din, ed);
      req_valid = 4'h0;
      req_data = $urandom;
      step();
      check({nm, " start_clr"}, tx_start, 0);
      check({nm, " din_hold"}, tx_din, ed);
      done_pulse();
      check({nm, " idle"}, busy, 0);
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && busy; k++) step();
      check("drain timeout", busy, 0);
   endtask

   initial begin
      int nf, er, eg, left, ptr, idx;
      vt[0] = '{4'b0100, 8'h58, 4'b0100, 2'd2, 8'h5A};
      vt[1] = '{4'b1001, 8'h20, 4'b1000, 2'd3, 8'h23};
      vt[2] = '{4'b1001, 8'h30, 4'b0001, 2'd0, 8'h30};
      vt[3] = '{4'b0001, 8'h40, 4'b0001, 2'd0, 8'h40};
      vt[4] = '{4'b0110, 8'h50, 4'b0010, 2'd1, 8'h51};
      vt[5] = '{4'b0011, 8'h60, 4'b0001, 2'd0, 8'h60};
      vt[6] = '{4'b1000, 8'h70, 4'b1000, 2'd3, 8'h73};
      vt[7] = '{4'b1111, 8'h80, 4'b0001, 2'd0, 8'h80};

      // reset with all requesters pending
      reset_n = 1'b0;
      req_valid = 4'hF;
      req_data = pack(8'h10);
      repeat (3) step();
      check("rst ready", req_ready, 0);
      check("rst start", tx_start, 0);
      check("rst busy", busy, 0);
      check("rst din", tx_din, 0);
      check("rst grant", grant_id, 0);
      req_valid = 4'h0;
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         req_valid = vt[i].valid;
         req_data = pack(vt[i].base);
         #1;
         check($sformatf("vec%0d ready", i), req_ready, vt[i].ready);
         step();
         serve($sformatf("vec%0d", i), vt[i].grant, vt[i].din);
      end

      // stray done in idle leaves the pointer at 1
      done_pulse();
      check("stray busy", busy, 0);
      check("stray start", tx_start, 0);
      req_valid = 4'hF;
      req_data = pack(8'hC0);
      #1;
      check("stray ptr", req_ready, 4'b0010);
      step();
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      check("done_on_start busy", busy, 1);
      reset_n = 1'b0;
      step();
      check("midrst busy", busy, 0);
      check("midrst start", tx_start, 0);
      check("midrst din", tx_din, 0);
      reset_n = 1'b1;
      req_data = pack(8'h90);
      #1;
      check("midrst ptr", req_ready, 4'b0001);
      step();
      serve("midrst", 2'd0, 8'h90);

      // rotation with all requesters valid
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      sent.delete();
      start_cyc.delete();
      auto_tx = 1;
      req_valid = 4'hF;
      req_data = pack(8'h10);
      nf = 5 * FPG;
      for (int k = 0; k < 300 && sent.size() < nf; k++) step();
      req_valid = 4'h0;
      check("rot timeout", sent.size() >= nf, 1);
      for (int j = 0; j < nf && j < sent.size(); j++) begin
`ifdef UART_ARB_TAG_EN
         check($sformatf("rot byte%0d", j), sent[j],
               (j % 2 == 0) ? 8'hA0 | 8'((j / 2) % 4) : 8'h10 + 8'((j / 2) % 4));
         if (j > 0)
            check($sformatf("rot gap%0d", j), start_cyc[j] - start_cyc[j-1],
                  (j % 2 == 1) ? F + 1 : F + 2);
`else
         check($sformatf("rot byte%0d", j), sent[j], 8'h10 + 8'(j % 4));
         if (j > 0)
            check($sformatf("rot gap%0d", j), start_cyc[j] - start_cyc[j-1], F + 2);
`endif
      end
      drain();

      // randomized traffic against a grant-level reference model
      auto_tx = 0;
      tx_done_tick = 1'b0;
      tx_cnt = 0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      auto_tx = 1;
      sent.delete();
      exp_q.delete();
      left = 0;
      ptr = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            req_valid = 4'($urandom);
            req_data = $urandom;
         end
         #1;
         er = 0;
         eg = 0;
         if (left == 0)
            for (int k = 0; k < N; k++) begin
               idx = (ptr + k) % N;
               if (er == 0 && req_valid[idx]) begin
                  er = 1 << idx;
                  eg = idx;
               end
            end
         check("rand ready", req_ready, er);
         check("rand busy", busy, left != 0);
         if (er != 0) begin
            left = FPG;
            ptr = (eg + 1) % N;
`ifdef UART_ARB_TAG_EN
            exp_q.push_back(8'hA0 | 8'(eg));
`endif
            exp_q.push_back(req_data[eg*8 +: 8]);
         end else if (left > 0 && tx_done_tick) begin
            left--;
         end
         step();
      end
      req_valid = 4'h0;
      drain();
      check("rand count", sent.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < sent.size(); j++)
         check($sformatf("rand byte%0d", j), sent[j], exp_q[j]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
